serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller. Computes A - B - Bin on WIDTH-bit operands using one full-subtractor cell over WIDTH clock cycles, LSB first.
- A registered borrow chains the bits from one cycle to the next.
- Start/busy/done handshake, so a host FSM or switch/LED top level can issue subtractions without a WIDTH-wide ripple datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; sampled on a rising edge.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; diff/bout are valid from this cycle on.
- diff  output  WIDTH  difference a - b - bin mod 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, operand shift registers=0, borrow register=0. Reset mid-RUN aborts the operation; no done pulse is produced for the aborted operation.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0.
  - start=1 at an edge: latch a, b into shift registers, borrow register <= bin, counter <= 0, go to RUN.
- RUN: busy=1, done=0. At each edge:
  - d = a_sr[0] ^ b_sr[0] ^ br.
  - br <= (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br).
  - d shifts into the result shift register from the MSB side; a_sr and b_sr shift right by 1; counter increments.
  - On the edge where counter == WIDTH-1, go to DONE. diff <= completed result (including this final bit); bout <= final borrow.
  - start is ignored in RUN; operands are not re-sampled.
- DONE: lasts exactly one cycle. busy=0, done=1.
  - start=1 at the exiting edge: accepted exactly as from IDLE, go to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0; done is high from edge E(WIDTH) to E(WIDTH+1). Back-to-back throughput is one operation per WIDTH+1 cycles.
- diff and bout are registered outputs. They change only on the RUN->DONE edge or on reset, and hold their value through subsequent IDLE/RUN until the next completion.
- a, b, bin may change freely after the accept edge without affecting the in-flight operation.
- Wrap-around: the result is modulo 2^WIDTH; the borrow is reported only on bout (e.g. 0x00 - 0x01 gives diff=0xFF, bout=1).
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1 and resets to 0 on each accept.

Optional Feature:
- Macro: SERSUB_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, reset 0).
  - A zero-accumulator register is cleared on accept and ORs in each d during RUN.
  - On the RUN->DONE edge, zero <= ~(accumulator | final d), i.e. 1 iff diff == 0.
  - zero is updated and held with the same timing as diff.
- Undefined: no zero port, no accumulator logic. All other behaviour is identical.

Test Plan:
- Reset, then WIDTH=8, a=0x5A, b=0x3C, bin=0, start 1 cycle -> busy high for 8 cycles; done pulses at E8 with diff=0x1E, bout=0 (zero=0 if enabled).
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1; a=0x10, b=0x10, bin=0 -> diff=0x00, bout=0, zero=1 if enabled.
- start held high continuously with operands changed every cycle -> ops accepted only at E0, E9, E18; each result matches the operands present at its accept edge; done pulses spaced 9 cycles apart.
- start pulsed again at E3 of a running op with different a/b -> ignored; result equals the first op; no extra done pulse.
- rst asserted asynchronously mid-RUN at cycle 4 -> busy, done, diff, bout drop to 0 immediately; no done pulse; a new start after reset release completes correctly.
- Random a, b, bin over 1000 ops (WIDTH=8 and WIDTH=16) -> diff/bout equal the reference model {bout,diff} = a - b - bin in WIDTH+1 bits; latency is always WIDTH cycles to done.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial WIDTH-bit subtractor. Computes diff = a - b - bin (mod 2^WIDTH)
// and bout (final borrow) with one full-subtractor cell, LSB first, one bit
// per clock. A registered borrow carries each bit's borrow into the next
// cycle.
//
// Handshake: start is sampled on a rising edge while the block is not busy
// (IDLE, or the single DONE cycle for back-to-back issue). When start is seen
// there, a/b/bin are captured. busy is high for the WIDTH RUN cycles that
// follow. done pulses for one cycle afterwards. diff/bout (and zero) are valid
// from the done cycle on and hold until the next completion. start is ignored
// while busy.
//
// Optional feature: define SERSUB_ZERO_FLAG_EN to add the zero output. It is 1
// when the completed diff equals 0 and follows the same timing as diff.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request a subtraction
//   a      in   [WIDTH-1:0] minuend, captured when start is seen
//   b      in   [WIDTH-1:0] subtrahend, captured when start is seen
//   bin    in   borrow-in, captured when start is seen
//   busy   out  operation in progress (RUN)
//   done   out  one-cycle completion pulse (DONE)
//   diff   out  [WIDTH-1:0] registered difference
//   bout   out  registered final borrow-out
//   zero   out  registered diff==0 flag (only with SERSUB_ZERO_FLAG_EN)
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operand shift registers and the serial borrow.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    // Result bits gathered so far. The final bit of each operation is
    // combined directly into diff, so only WIDTH-1 bits need storage.
    logic [WIDTH-2:0] res_sr;

    logic             d;
    logic             br_next;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] res_wide;

`ifdef SERSUB_ZERO_FLAG_EN
    logic             zacc;
`endif

    // ---------------------------------------------------------------------
    // Full-subtractor cell on the current LSBs.
    // ---------------------------------------------------------------------
    assign d       = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);

    // The new bit enters from the MSB side. After the last bit this value is
    // the complete result, with bit 0 in the LSB.
    assign res_wide = {d, res_sr};
    assign last_bit = (cnt == LAST);

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // DONE may accept a new operation, so back-to-back issue
                // costs WIDTH+1 cycles per operation.
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Serial datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            res_sr <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            cnt    <= '0;
            res_sr <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br     <= br_next;
            res_sr <= res_wide[WIDTH-1:1];
            // Hold at the last index so the counter never exceeds WIDTH-1.
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Result registers: these change only when an operation completes
    // (RUN->DONE) or on reset.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            diff <= res_wide;
            bout <= br_next;
        end
    end

`ifdef SERSUB_ZERO_FLAG_EN
    // The accumulator ORs together every result bit produced so far. zero
    // is its inverse after the final bit is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zacc <= 1'b0;
            zero <= 1'b0;
        end else if (accept) begin
            zacc <= 1'b0;
        end else if (state == RUN) begin
            zacc <= zacc | d;
            if (last_bit) begin
                zero <= ~(zacc | d);
            end
        end
    end
`endif

endmodule
